// File: rtl/count_ctrl_pkg.sv
// Shared definitions for the counter command sequencer and the 5-bit loadable counter it drives.
package count_ctrl_pkg;

    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        OP_NOP    = 2'b00,
        OP_LOAD   = 2'b01,
        OP_RUN_N  = 2'b10,
        OP_RUN_TO = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RUN    = 3'd2,
        ST_RUN_TO = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

endpackage

// File: rtl/count_ctrl.sv
// Command sequencer that turns LOAD / RUN_N / RUN_TO commands into load/enable/data
// for a downstream loadable counter, pulsing done when a command completes normally.
module count_ctrl
    import count_ctrl_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             abort,
    input  logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] data,
    output logic             load,
    output logic             enable,
    output logic             busy,
    output logic             done,
    output state_e           dbg_state
);

    localparam logic [WIDTH:0] REM_ONE  = (WIDTH+1)'(1);
    localparam logic [WIDTH:0] REM_FULL = {1'b1, {WIDTH{1'b0}}};

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH:0]   remaining_q;
    logic             accept;
    op_e              op;

    // Handshake: a command transfers on the rising edge where cmd_valid && cmd_ready.
    // cmd_ready depends only on state (high in IDLE), and cmd_* are sampled only then.
    assign accept = cmd_valid && cmd_ready;
    assign op     = op_e'(cmd_op);

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        enable    = 1'b0;
        done      = 1'b0;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    case (op)
                        OP_LOAD:   state_d = ST_LOAD;
                        OP_RUN_N:  state_d = ST_RUN;
                        OP_RUN_TO: state_d = ST_RUN_TO;
                        default:   state_d = ST_IDLE;
                    endcase
                end
            end
            ST_LOAD: begin
                load    = 1'b1;
                state_d = ST_DONE;
            end
            ST_RUN: begin
                enable = 1'b1;
                if (remaining_q == REM_ONE) begin
                    state_d = ST_DONE;
                end
            end
            ST_RUN_TO: begin
                // Stop counting in the cycle the target is seen so the counter never overshoots.
                enable = (count != data_q);
                if (count == data_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q     <= ST_IDLE;
            data_q      <= '0;
            remaining_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                case (op)
                    OP_LOAD:   data_q <= cmd_data;
                    OP_RUN_N:  remaining_q <= (cmd_data == '0) ? REM_FULL : {1'b0, cmd_data};
                    OP_RUN_TO: data_q <= cmd_data;
                    default:   ;
                endcase
            end else if (state_q == ST_RUN) begin
                remaining_q <= remaining_q - REM_ONE;
            end
        end
    end

    assign data      = data_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_count_ctrl.sv
// Bench for count_ctrl: a behavioural counter closes the loop, and each command is
// expanded into its expected per-cycle output trace from the command semantics.
module tb_count_ctrl;
    import count_ctrl_pkg::*;

    localparam int W = CNT_W;

    typedef struct packed {
        logic         ld;
        logic         en;
        logic         dn;
        logic         cd;
        logic [W-1:0] dat;
        logic [W-1:0] cnt;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_;
    logic         cnt_rst_;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_data;
    logic         abort;
    logic [W-1:0] count;
    logic [W-1:0] data;
    logic         load;
    logic         enable;
    logic         busy;
    logic         done;
    state_e       dbg_state;

    int           n_vec = 0;
    int           n_err = 0;
    logic [W-1:0] mcount;
    exp_t         exp_q[$];

    always #5 clk = ~clk;

    count_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_      (rst_),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .abort     (abort),
        .count     (count),
        .data      (data),
        .load      (load),
        .enable    (enable),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // Downstream 5-bit loadable counter with its own reset.
    always_ff @(posedge clk or negedge cnt_rst_) begin
        if (!cnt_rst_)   count <= '0;
        else if (load)   count <= data;
        else if (enable) count <= count + 1'b1;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(logic ld, logic en, logic dn, logic cd,
                                logic [W-1:0] dat, logic [W-1:0] cnt);
        exp_t e;
        e.ld = ld; e.en = en; e.dn = dn; e.cd = cd; e.dat = dat; e.cnt = cnt;
        return e;
    endfunction

    // Expected busy-cycle trace of a command, starting from the modelled count.
    task automatic plan(input logic [1:0] op, input logic [W-1:0] d);
        logic [W-1:0] c;
        logic [W-1:0] k;
        int           n;
        c = mcount;
        exp_q.delete();
        case (op)
            2'b01: begin
                exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, d, c));
                exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, '0, d));
            end
            2'b10: begin
                n = (d == 0) ? 32 : int'(d);
                for (int i = 0; i < n; i++) exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, '0, c + W'(i)));
                exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, '0, c + W'(n)));
            end
            2'b11: begin
                k = d - c;
                for (int i = 0; i < int'(k); i++) exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, '0, c + W'(i)));
                exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, '0, d));
                exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, '0, d));
            end
            default: ;
        endcase
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".ready"},  8'(cmd_ready), 8'd1);
        chk({tag, ".busy"},   8'(busy),      8'd0);
        chk({tag, ".done"},   8'(done),      8'd0);
        chk({tag, ".load"},   8'(load),      8'd0);
        chk({tag, ".enable"}, 8'(enable),    8'd0);
        chk({tag, ".state"},  8'(dbg_state), 8'(ST_IDLE));
        chk({tag, ".count"},  8'(count),     8'(mcount));
    endtask

    // Called at a negedge with the controller idle; returns at a negedge, idle again.
    task automatic do_cmd(input logic [1:0] op, input logic [W-1:0] d, input int abort_at,
                          input int rst_at, input bit abort_idle, input bit scramble);
        bit   was_reset;
        exp_t e;
        was_reset = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        abort     = abort_idle;
        chk("accept.ready", 8'(cmd_ready), 8'd1);
        plan(op, d);
        @(posedge clk);
        foreach (exp_q[i]) begin
            @(negedge clk);
            e = exp_q[i];
            cmd_valid = scramble;
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_data  = W'($urandom);
            abort     = (i == abort_at);
            if (i == rst_at) begin
                rst_ = 1'b0;
                #1;
                chk("rst.load",   8'(load),      8'd0);
                chk("rst.enable", 8'(enable),    8'd0);
                chk("rst.done",   8'(done),      8'd0);
                chk("rst.ready",  8'(cmd_ready), 8'd1);
                chk("rst.busy",   8'(busy),      8'd0);
                chk("rst.data",   8'(data),      8'd0);
                mcount = e.cnt;
                @(negedge clk);
                rst_      = 1'b1;
                was_reset = 1'b1;
                break;
            end
            chk("trace.load",   8'(load),      8'(e.ld));
            chk("trace.enable", 8'(enable),    8'(e.en));
            chk("trace.done",   8'(done),      8'(e.dn));
            chk("trace.busy",   8'(busy),      8'd1);
            chk("trace.ready",  8'(cmd_ready), 8'd0);
            chk("trace.count",  8'(count),     8'(e.cnt));
            if (e.cd) chk("trace.data", 8'(data), 8'(e.dat));
            if (i == abort_at) begin
                mcount = e.ld ? e.dat : e.cnt + W'(e.en);
                break;
            end
            if (i == exp_q.size() - 1) mcount = e.cnt;
        end
        if (!was_reset) @(negedge clk);
        cmd_valid = 1'b0;
        abort     = 1'b0;
        chk_idle("idle");
    endtask

    initial begin
        int ab;
        rst_      = 1'b0;
        cnt_rst_  = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = '0;
        abort     = 1'b0;
        mcount    = '0;
        #1;
        chk("por.data", 8'(data), 8'd0);
        chk_idle("por");
        repeat (3) @(negedge clk);
        rst_     = 1'b1;
        cnt_rst_ = 1'b1;
        @(negedge clk);

        // Reset in the middle of a run, then a LOAD right after release.
        do_cmd(2'b10, 5'd20, -1, 5, 1'b0, 1'b1);
        do_cmd(2'b01, 5'd17, -1, -1, 1'b0, 1'b1);
        // RUN_N 0 means a full 32-cycle lap.
        do_cmd(2'b01, 5'd3, -1, -1, 1'b0, 1'b1);
        do_cmd(2'b10, 5'd0, -1, -1, 1'b0, 1'b1);
        // RUN_TO through the wrap, then RUN_TO the value already present.
        do_cmd(2'b01, 5'd28, -1, -1, 1'b0, 1'b1);
        do_cmd(2'b11, 5'd2, -1, -1, 1'b0, 1'b1);
        do_cmd(2'b11, 5'd2, -1, -1, 1'b0, 1'b1);
        // Abort in the third enabled cycle; abort in IDLE alongside a LOAD.
        do_cmd(2'b10, 5'd10, 2, -1, 1'b0, 1'b1);
        do_cmd(2'b01, 5'd9, -1, -1, 1'b1, 1'b1);
        do_cmd(2'b00, 5'd21, -1, -1, 1'b0, 1'b1);
        do_cmd(2'b10, 5'd1, -1, -1, 1'b0, 1'b0);

        for (int t = 0; t < 80; t++) begin
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 34)) : -1;
            do_cmd(2'($urandom_range(0, 3)), W'($urandom), ab, -1,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/count_ctrl.md
# count_ctrl

Command sequencer that sits directly upstream of the 5-bit loadable counter and drives its `data`, `load` and `enable` inputs. It accepts one command at a time over a valid/ready handshake and turns it into counter control:

- **LOAD**: load a value.
- **RUN_N**: count for N cycles.
- **RUN_TO**: count until the counter output equals a target.

It watches the counter's `count` output and signals completion with a one-cycle `done` pulse.

## Interface
- `WIDTH`, default 5: counter/data width; must match the downstream counter.
- `clk` input 1: clock; all state updates on rising edge.
- `rst_` input 1: reset, asynchronous, active-low.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: controller can accept a command (high only in IDLE).
- `cmd_op` input 2: operation. 00 NOP, 01 LOAD, 10 RUN_N, 11 RUN_TO.
- `cmd_data` input WIDTH: load value, run length N, or target, depending on op.
- `abort` input 1: synchronous abort of the command in progress.
- `count` input WIDTH: counter output (registered in the counter).
- `data` output WIDTH: value to counter `data`.
- `load` output 1: to counter `load`.
- `enable` output 1: to counter `enable`.
- `busy` output 1: state ≠ IDLE.
- `done` output 1: one-cycle pulse when a LOAD/RUN_N/RUN_TO completes normally.

## Operation
- **States**: IDLE, LOAD, RUN, RUN_TO, DONE. The state register, a `data`/target register and a WIDTH+1-bit `remaining` register are all reset asynchronously.
- **Reset values**: state=IDLE, `data`=0, `remaining`=0, `load`=0, `enable`=0, `done`=0, `busy`=0, `cmd_ready`=1.
- **Handshake**: a command is accepted on a rising edge with `cmd_valid`&&`cmd_ready`. `cmd_*` are sampled only at acceptance.
- **Acceptance by op**:
  - NOP: accepted with no effect; the controller stays IDLE and no `done` is issued.
  - LOAD: data←`cmd_data`, go to LOAD.
  - RUN_N: remaining←`cmd_data`, with 0 meaning 2^WIDTH (32); go to RUN.
  - RUN_TO: target←`cmd_data`, go to RUN_TO.
- **LOAD**: `load`=1 and `data`=value for exactly one cycle, then DONE.
- **RUN**:
  - `enable`=1 every cycle in RUN.
  - `remaining` decrements each edge.
  - On the edge where `remaining`==1, go to DONE.
- **RUN_TO**:
  - `enable` = (`count` ≠ target), decoded combinationally from state and `count`. No path exists from `cmd_*` to outputs.
  - When `count`==target, go to DONE on the next edge with `enable`=0, so there is no overshoot.
- **DONE**: `done`=1 for one cycle, `cmd_ready`=0, then IDLE.
- **Outputs outside their state**: `load`=0 and `enable`=0 outside LOAD/RUN/RUN_TO. `data` holds its last value.
- **Wrap-around**: the counter wraps 31→0, so RUN_TO always terminates within 32 enabled cycles. A target below the current count is reached via wrap.
- **RUN_TO with `count`==target at entry**: `enable` never asserts; DONE follows one cycle later.
- **`abort`**:
  - Highest priority in any non-IDLE state: next state is IDLE and no `done` is issued.
  - `load`/`enable` are already 0 in the cycle after the abort edge.
  - An abort in IDLE is ignored and does not block acceptance.
- **`rst_` mid-operation**: returns immediately to the reset values above; the counter's own reset is independent.

## Timing
- Command accepted at edge k. The counter changes at edge k+1 (LOAD) or starting at edge k+1 (RUN/RUN_TO).
- **LOAD**: `load` high during cycle k→k+1; `count`=value after k+1; `done` high during k+1→k+2; `cmd_ready` high again after k+2.
- **RUN_N**: `enable` high for exactly N cycles (k+1..k+N edges increment); `done` high for the following cycle. Net count change is +N mod 32.
- **RUN_TO**: the cycle in which `count` first equals target has `enable`=0. `done` is high in the following cycle.
- **Back-to-back**: the minimum command-to-command spacing is the command duration plus the DONE cycle. `cmd_ready` is combinational from state.

## Structure
- **Shared package `count_ctrl_pkg`**:
  - `op_e` enum: NOP, LOAD, RUN_N, RUN_TO.
  - `state_e` enum: IDLE, LOAD, RUN, RUN_TO, DONE.
  - `CNT_W`=5 constant, shared with the counter.
- **Sub-modules**: none is natural; single module with one `always_ff` for state and registers plus one `always_comb` for next-state and output decode.
- **Top level**: instantiates `count_ctrl` alongside the counter, wiring `count` back.

## Test plan
- **Reset**: `rst_`=0 mid-RUN → `load`/`enable`/`done`=0, `cmd_ready`=1, `busy`=0 immediately. Release, then LOAD 5'd17 → `count`=17 at edge k+1, `done` at k+1→k+2.
- **RUN_N with N=0**: LOAD 3 then RUN_N 0 → `enable` high 32 cycles, `count` returns to 3, single `done` pulse.
- **RUN_TO with wrap**: LOAD 28 then RUN_TO 2 → `count` 29,30,31,0,1,2 then stops; `enable` low in the cycle `count`=2; `done` next cycle. Also RUN_TO 2 with `count`=2 → no enable, `done` after one cycle.
- **Abort**: RUN_N 10 with `abort` at third enable cycle → exactly 3 increments, `done` never asserts, IDLE next cycle. Abort in IDLE with simultaneous LOAD command → LOAD accepted.
- **Handshake**: `cmd_valid` held high with changing `cmd_data` while busy → only the value present at acceptance is used. NOP → `cmd_ready` stays 1, no `done`.
